// File: rtl/ad9228_lane_emulator.sv
// Transmit-side model of one AD9228 LVDS lane: FIFO-fed 12-bit samples (or built-in
// test patterns) serialized MSB first with matching frame clock and bit-rate data clock.
module ad9228_lane_emulator #(
  parameter int DATA_WIDTH    = 12,
  parameter int FCO_HIGH_BITS = DATA_WIDTH / 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  enable,
  input  logic [1:0]            test_mode,
  input  logic                  dco_phase,
  output logic                  dout,
  output logic                  fco,
  output logic                  dco,
  output logic                  frame_start,
  output logic                  underflow,
  output logic [15:0]           frame_count
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] FCO_LIM  = CW'(FCO_HIGH_BITS);
  localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);

  localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] PAT_A    = DATA_WIDTH'({(DATA_WIDTH/2){2'b10}});
  localparam logic [DATA_WIDTH-1:0] PAT_B    = ~PAT_A;

  typedef enum logic {IDLE, RUN} state_e;
  typedef enum logic [1:0] {TM_NORMAL = 2'b00, TM_MID = 2'b01,
                            TM_CHECK  = 2'b10, TM_RAMP = 2'b11} test_mode_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  load;

  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] ramp_q, ramp_d;
  logic                  cb_q, cb_d;
  logic                  phase_q, phase_d;
  logic                  underflow_q, underflow_d;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [NW-1:0]         count_q, count_d;
  logic                  push, pop, fifo_empty;
  logic                  s_ready_q;

  logic                  dout_q, dout_d;
  logic                  fco_q, fco_d;
  logic                  dco_q, dco_d;
  logic                  fs_q, fs_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic [CW-1:0]         bit_idx;

  assign fifo_empty = (count_q == '0);
  assign push       = s_valid && s_ready_q;
  assign count_d    = count_q + NW'(push) - NW'(pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      word_q        <= '0;
      ramp_q        <= '0;
      cb_q          <= 1'b0;
      phase_q       <= 1'b0;
      underflow_q   <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      s_ready_q     <= 1'b0;
      dout_q        <= 1'b0;
      fco_q         <= 1'b0;
      dco_q         <= 1'b0;
      fs_q          <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      word_q        <= word_d;
      ramp_q        <= ramp_d;
      cb_q          <= cb_d;
      phase_q       <= phase_d;
      underflow_q   <= underflow_d;
      rd_ptr_q      <= pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      wr_ptr_q      <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      count_q       <= count_d;
      s_ready_q     <= (count_d != FULL_CNT);
      dout_q        <= dout_d;
      fco_q         <= fco_d;
      dco_q         <= dco_d;
      fs_q          <= fs_d;
      frame_count_q <= frame_count_d;
    end
  end

  // NOTE: sample storage carries no reset; occupancy is tracked by the pointers and
  // count, so stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_data;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          load      = 1'b1;
          state_d   = RUN;
          bit_cnt_d = '0;
        end
      end
      RUN: begin
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          if (enable) load    = 1'b1;
          else        state_d = IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame word selection; test_mode and dco_phase only matter at a load.
  always_comb begin
    word_d      = word_q;
    ramp_d      = ramp_q;
    cb_d        = cb_q;
    phase_d     = phase_q;
    underflow_d = underflow_q;
    pop         = 1'b0;
    if (load) begin
      phase_d = dco_phase;
      case (test_mode_e'(test_mode))
        TM_NORMAL: begin
          if (fifo_empty) begin
            underflow_d = 1'b1;
          end else begin
            pop    = 1'b1;
            word_d = mem[rd_ptr_q];
          end
        end
        TM_MID:   word_d = MIDSCALE;
        TM_CHECK: begin
          word_d = cb_q ? PAT_B : PAT_A;
          cb_d   = ~cb_q;
        end
        TM_RAMP: begin
          word_d = ramp_q;
          ramp_d = ramp_q + 1'b1;
        end
        default: word_d = word_q;
      endcase
    end
  end

  // Outputs are registered from next-state values so the MSB leaves the cycle after a load.
  always_comb begin
    dout_d        = 1'b0;
    fco_d         = 1'b0;
    dco_d         = 1'b0;
    fs_d          = 1'b0;
    frame_count_d = frame_count_q;
    bit_idx       = LAST_BIT - bit_cnt_d;
    if (state_d == RUN) begin
      dout_d = word_d[bit_idx];
      fco_d  = (bit_cnt_d < FCO_LIM);
      dco_d  = ~(bit_cnt_d[0] ^ phase_d);
      fs_d   = (bit_cnt_d == '0);
    end
    if (load) frame_count_d = frame_count_q + 16'd1;
  end

  assign s_ready     = s_ready_q;
  assign dout        = dout_q;
  assign fco         = fco_q;
  assign dco         = dco_q;
  assign frame_start = fs_q;
  assign underflow   = underflow_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ad9228_lane_emulator.sv
// Self-checking bench for ad9228_lane_emulator: frame-level reference model with
// per-cycle comparison, directed scenarios pinned by literal expectations, random soak.
module tb_ad9228_lane_emulator;

  localparam int DW    = 12;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          enable;
  logic [1:0]    test_mode;
  logic          dco_phase;
  logic          dout, fco, dco, frame_start, underflow;
  logic [15:0]   frame_count;

  ad9228_lane_emulator #(.DATA_WIDTH(DW), .FCO_HIGH_BITS(DW/2), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .enable(enable), .test_mode(test_mode), .dco_phase(dco_phase),
    .dout(dout), .fco(fco), .dco(dco), .frame_start(frame_start),
    .underflow(underflow), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the lane is either idle or partway through a frame of a known word.
  logic          chk_en = 1'b0;
  logic [DW-1:0] m_q [$];
  logic          m_ready, m_running, m_phase, m_uf, m_cb, m_push;
  logic [DW-1:0] m_held, m_ramp;
  logic [15:0]   m_fc;
  int            m_pos;

  // Deserialized frames recovered from the DUT's serial output.
  logic [DW-1:0] rx_q [$];
  logic [DW-1:0] rx_sh;
  int            rx_n = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_ready = 1'b0; m_running = 1'b0; m_phase = 1'b0; m_uf = 1'b0; m_cb = 1'b0;
      m_held = '0; m_ramp = '0; m_fc = '0; m_pos = 0;
      chk_en = 1'b1;
    end else if (chk_en) begin
      m_push = s_valid && m_ready;
      if (m_running && m_pos != DW - 1) begin
        m_pos++;
      end else if (enable) begin
        case (test_mode)
          2'b00: if (m_q.size() == 0) m_uf = 1'b1; else m_held = m_q.pop_front();
          2'b01: m_held = 12'h800;
          2'b10: begin m_held = m_cb ? 12'h555 : 12'hAAA; m_cb = ~m_cb; end
          default: begin m_held = m_ramp; m_ramp = m_ramp + 12'd1; end
        endcase
        m_running = 1'b1; m_pos = 0; m_phase = dco_phase; m_fc = m_fc + 16'd1;
      end else begin
        m_running = 1'b0;
      end
      if (m_push) m_q.push_back(s_data);
      m_ready = (m_q.size() < DEPTH);
    end
    #1;
    if (chk_en) begin
      check("dout",        dout,        m_running ? m_held[DW-1-m_pos] : 1'b0);
      check("fco",         fco,         m_running && (m_pos < DW/2));
      check("dco",         dco,         m_running && ((m_pos % 2) == int'(m_phase)));
      check("frame_start", frame_start, m_running && (m_pos == 0));
      check("underflow",   underflow,   m_uf);
      check("frame_count", frame_count, m_fc);
      check("s_ready",     s_ready,     m_ready);
    end
    if (rst) begin
      rx_n = 0;
    end else if (frame_start) begin
      rx_sh = {{(DW-1){1'b0}}, dout};
      rx_n  = 1;
    end else if (rx_n > 0) begin
      rx_sh = {rx_sh[DW-2:0], dout};
      rx_n++;
    end
    if (rx_n == DW) begin
      rx_q.push_back(rx_sh);
      rx_n = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    int b = 0;
    s_valid = 1'b1; s_data = w;
    while (s_ready !== 1'b1 && b < 200) begin tick(1); b++; end
    check("push_ready", s_ready, 1'b1);
    tick(1);
    s_valid = 1'b0;
  endtask

  task automatic wait_fc(input logic [15:0] target, input int budget);
    int b = 0;
    while (frame_count !== target && b < budget) begin tick(1); b++; end
    check("wait_fc", frame_count, target);
  endtask

  task automatic check_rx(input string name, input int idx, input logic [DW-1:0] exp);
    logic [31:0] got;
    got = (idx >= 0 && idx < rx_q.size()) ? 32'(rx_q[idx]) : 32'hDEAD_BEEF;
    check(name, got, 32'(exp));
  endtask

  logic [DW-1:0] seq1 [9] = '{12'h000, 12'h000, 12'h000, 12'hFFF, 12'h001,
                              12'hFFF, 12'h001, 12'h03F, 12'h001};
  logic [DW-1:0] seq7 [5] = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555};
  int base;

  initial begin
    rst = 1'b1; s_data = '0; s_valid = 1'b0; enable = 1'b0; test_mode = 2'b00; dco_phase = 1'b0;
    tick(2);
    check("rst_fc", frame_count, 16'd0);
    check("rst_ready", s_ready, 1'b0);
    rst = 1'b0;
    tick(1);
    check("ready_after_rst", s_ready, 1'b1);

    // Back-to-back normal frames fed as fast as the FIFO drains.
    base = rx_q.size();
    for (int i = 0; i < 4; i++) push_word(seq1[i]);
    enable = 1'b1;
    for (int i = 4; i < 9; i++) push_word(seq1[i]);
    wait_fc(16'd9, 300);
    enable = 1'b0;
    tick(16);
    for (int i = 0; i < 9; i++) check_rx("seq1_word", base + i, seq1[i]);
    check("seq1_fc", frame_count, 16'd9);
    check("seq1_uf", underflow, 1'b0);

    // Underflow re-sends the held sample and stays sticky.
    do_reset();
    base = rx_q.size();
    push_word(12'hA5C);
    enable = 1'b1;
    wait_fc(16'd1, 50);
    check("uf_frame1", underflow, 1'b0);
    wait_fc(16'd2, 50);
    check("uf_frame2", underflow, 1'b1);
    enable = 1'b0;
    tick(30);
    check("uf_sticky", underflow, 1'b1);
    check_rx("uf_word1", base, 12'hA5C);
    check_rx("uf_word2", base + 1, 12'hA5C);

    // Checkerboard and ramp wrap with a full FIFO left untouched.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_word(12'h123);
    check("full_ready", s_ready, 1'b0);
    base = rx_q.size();
    test_mode = 2'b10; enable = 1'b1;
    wait_fc(16'd3, 60);
    enable = 1'b0;
    tick(16);
    check_rx("cb0", base, 12'hAAA);
    check_rx("cb1", base + 1, 12'h555);
    check_rx("cb2", base + 2, 12'hAAA);
    test_mode = 2'b11; enable = 1'b1;
    wait_fc(16'd4100, 60000);
    enable = 1'b0;
    tick(16);
    check_rx("ramp_ffe", rx_q.size() - 3, 12'hFFE);
    check_rx("ramp_fff", rx_q.size() - 2, 12'hFFF);
    check_rx("ramp_000", rx_q.size() - 1, 12'h000);
    check("ramp_fifo_full", s_ready, 1'b0);
    test_mode = 2'b00; enable = 1'b1;
    wait_fc(16'd4101, 30);
    enable = 1'b0;
    tick(16);
    check_rx("fifo_kept", rx_q.size() - 1, 12'h123);

    // dco_phase=1 and a mid-frame phase toggle that must not take effect.
    test_mode = 2'b01; dco_phase = 1'b1; enable = 1'b1;
    wait_fc(16'd4102, 30);
    check("ph1_dco_msb", dco, 1'b0);
    enable = 1'b0;
    tick(3);
    dco_phase = 1'b0;
    tick(16);
    check_rx("mid_word", rx_q.size() - 1, 12'h800);

    // Dropping enable at bit 5 completes the frame, then the lane idles.
    enable = 1'b1;
    wait_fc(16'd4103, 30);
    tick(5);
    enable = 1'b0;
    tick(20);
    check("en_drop_fc", frame_count, 16'd4103);
    check("en_drop_fco", fco, 1'b0);

    // Reset at bit 3 aborts the frame and clears sticky state.
    do_reset();
    test_mode = 2'b00; enable = 1'b1;
    wait_fc(16'd2, 40);
    check("pre_rst_uf", underflow, 1'b1);
    tick(3);
    rst = 1'b1; enable = 1'b0;
    tick(1);
    check("abort_dout", dout, 1'b0);
    check("abort_fco", fco, 1'b0);
    check("abort_dco", dco, 1'b0);
    check("abort_fc", frame_count, 16'd0);
    check("abort_uf", underflow, 1'b0);
    rst = 1'b0;
    tick(1);
    check("abort_ready", s_ready, 1'b1);

    // Fifth word is held by the source until the first load frees a slot.
    base = rx_q.size();
    for (int i = 0; i < 4; i++) push_word(seq7[i]);
    check("fill_ready", s_ready, 1'b0);
    s_valid = 1'b1; s_data = seq7[4]; enable = 1'b1;
    begin
      int b = 0;
      while (s_ready !== 1'b1 && b < 40) begin tick(1); b++; end
      check("fifth_accept", s_ready, 1'b1);
    end
    tick(1);
    s_valid = 1'b0;
    wait_fc(16'd5, 80);
    enable = 1'b0;
    tick(16);
    for (int i = 0; i < 5; i++) check_rx("fill_word", base + i, seq7[i]);
    check("fill_uf", underflow, 1'b0);

    // Random soak against the model.
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(0, 9) < 8);
      test_mode = 2'($urandom_range(0, 3));
      dco_phase = 1'($urandom_range(0, 1));
      s_valid   = 1'($urandom_range(0, 1));
      s_data    = DW'($urandom);
      rst       = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst = 1'b0; enable = 1'b0; s_valid = 1'b0;
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ad9228_lane_emulator.md
Name: ad9228_lane_emulator

Overview:
Transmit-side model of one AD9228 LVDS output lane, synthesizable for loopback and board bring-up. Accepts 12-bit parallel samples over a valid/ready handshake and serializes them MSB first, one bit per clk cycle. Produces the matching frame clock (fco) and bit-rate data clock (dco), so the output can drive the AD9228 deserializer path in hardware or in simulation. Also generates the ADC's built-in test patterns.

Parameters:
DATA_WIDTH, 12, sample width and bits per frame.
FCO_HIGH_BITS, DATA_WIDTH/2, number of leading bits in each frame during which fco is 1.
FIFO_DEPTH, 4, depth of the input sample FIFO (power of 2).

Ports:
clk  in  1  bit clock; one serial bit per cycle.
rst  in  1  synchronous, active-high reset.
s_data  in  DATA_WIDTH  sample to transmit.
s_valid  in  1  s_data is valid.
s_ready  out  1  FIFO can accept a sample.
enable  in  1  run the serial stream.
test_mode  in  2  00 normal, 01 midscale, 10 checkerboard, 11 ramp.
dco_phase  in  1  0: dco=1 on even bit indices; 1: dco=1 on odd bit indices.
dout  out  1  serial data bit.
fco  out  1  frame clock.
dco  out  1  data clock, a half-rate square wave aligned to the bit index.
frame_start  out  1  one-cycle pulse coincident with the MSB of each frame.
underflow  out  1  sticky flag: a frame was loaded in normal mode while the FIFO was empty.
frame_count  out  16  number of frames started; wraps at 0xFFFF to 0.

Behaviour:
- Reset values (all outputs registered): dout=0, fco=0, dco=0, frame_start=0, underflow=0, frame_count=0, s_ready=0 during the reset cycle. The FIFO is emptied, bit_cnt=0, held sample=0, ramp value=0, checkerboard phase=0, state=IDLE.
- rst asserted mid-frame aborts the frame immediately. No partial bits are emitted after the reset edge.
- FIFO:
  - s_ready = !full, registered.
  - A push occurs when s_valid && s_ready.
  - A pop occurs only at a normal-mode frame load.
  - Push and pop in the same cycle are both honoured.
  - There is no bypass: a word pushed into an empty FIFO becomes loadable no earlier than the next cycle.
  - The FIFO accepts data in IDLE.
- State IDLE:
  - dout, fco, dco, frame_start are held at 0.
  - When enable=1, perform a LOAD and move to RUN. The MSB appears on dout the cycle after the LOAD.
- LOAD: test_mode and dco_phase are sampled here and held for the whole frame. The word is selected by test_mode:
  - 00: pop the FIFO head. If the FIFO is empty, re-send the held sample and set underflow.
  - 01: 0x800 (midscale).
  - 10: alternates per frame, 0xAAA first after reset, then 0x555, and so on.
  - 11: ramp value, then ramp value += 1 (wraps at 0xFFF to 0x000).
  - Test modes never pop the FIFO and never set underflow.
  - The loaded word becomes the held sample.
- State RUN: bit_cnt counts 0..DATA_WIDTH-1 and wraps. On each cycle:
  - dout = word[DATA_WIDTH-1-bit_cnt].
  - fco = (bit_cnt < FCO_HIGH_BITS).
  - dco = ~(bit_cnt[0] ^ dco_phase).
  - frame_start = (bit_cnt == 0).
  - frame_count increments on the cycle frame_start is asserted.
- Frame boundary, in the cycle bit_cnt = DATA_WIDTH-1:
  - If enable=1, LOAD the next word. The next frame's MSB follows back-to-back with no gap.
  - If enable=0, return to IDLE. Deasserting enable mid-frame always completes the current frame.
- Simultaneous events:
  - A FIFO push and a normal-mode LOAD pop in the same cycle with the FIFO empty: underflow is set and the pushed word is sent in the following frame.
  - A FIFO push and a pop with the FIFO full: s_ready was 0, so no push occurs.
- underflow is cleared only by rst.

Test Plan:
- Reset then push 0x000, 0x000, 0x000, 0xFFF, 0x001, 0xFFF, 0x001, 0x03F, 0x001 and hold enable=1 → dout frames match MSB first, back-to-back. fco is 1 for bits 0-5 and 0 for bits 6-11. dco reads 1,0,1,0… from each MSB. frame_count=9 after the 9th frame_start. underflow=0 while data keeps up.
- Push 0xA5C, set enable=1, and push nothing further → frame 1 = 0xA5C, frame 2 = 0xA5C (repeat), underflow=1 from the frame-2 load onward, stays 1 until rst.
- test_mode=10 for 3 frames → 0xAAA, 0x555, 0xAAA. test_mode=11 starting from ramp value 0xFFE → 0xFFE, 0xFFF, 0x000. A FIFO preloaded with 0x123 is still full-occupancy afterward.
- dco_phase=1 with word 0x800 → dco reads 0,1,0,1… relative to the MSB. Toggle dco_phase mid-frame → no change until the next LOAD.
- Deassert enable at bit 5 → bits 6-11 still sent, then outputs go to 0 and frame_count stops. Assert rst at bit 3 of a frame → the next cycle has dout=fco=dco=0, frame_count=0, underflow=0, FIFO empty, s_ready=1 after reset.
- Push 5 words back-to-back while IDLE with FIFO_DEPTH=4 → s_ready=0 after the 4th accept. The 5th word is held by the source and accepted after the first LOAD pop.
